// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Holds the program counter and fetches 32-bit RISC-V instruction words
//   from instruction memory using a valid/ready handshake. The fetched word
//   is held and split into the fields the control unit decodes. The next PC
//   is PC+4 or a branch/jump target, chosen when the instruction is accepted.
//
//   Optional feature macro: IFETCH_MISALIGN_CHECK_EN
//     defined   : a redirect to a target that is not word-aligned sets a sticky
//                 MisalignErr, keeps the old PC and halts fetching until rst.
//     undefined : target bits [1:0] are cleared, MisalignErr is tied 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request and address (= PC), combinational
//   imem_valid/imem_rdata    memory response, sampled only while imem_req=1
//   inst_valid/inst_ready    downstream handshake for the held instruction
//   Inst, OpCode, Funct3, Funct7, Rd, Rs1, Rs2   held word and its slices
//   PC, PCPlus4              address of the held instruction and PC+4
//   NextPCSrc, BranchTarget  redirect select and target, used at handshake
//   RetiredCount             accepted-instruction counter (wraps)
//   MisalignErr              sticky misaligned-target flag
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Inst,
  output logic [6:0]  OpCode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [4:0]  Rd,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        NextPCSrc,
  input  logic [31:0] BranchTarget,
  output logic [31:0] RetiredCount,
  output logic        MisalignErr
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_next;
  logic [31:0] pc, inst, retired, target;
  logic        halt, bad_target, hs, load;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign;
  assign bad_target  = NextPCSrc && (BranchTarget[1:0] != 2'b00);
  assign target      = BranchTarget;
  assign halt        = misalign;
  assign MisalignErr = misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   misalign <= 1'b0;
    else if (hs && bad_target) misalign <= 1'b1;
  end
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^BranchTarget[1:0];
  assign bad_target  = 1'b0;
  assign target      = {BranchTarget[31:2], 2'b00};
  assign halt        = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  // FSM: FETCH waits for memory, ISSUE holds the word until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    load       = 1'b0;
    hs         = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !halt;
        if (!halt && imem_valid) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          hs         = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // A misaligned redirect still retires the instruction but keeps the old PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      inst    <= NOP;
      retired <= 32'd0;
    end else begin
      if (load) inst <= imem_rdata;
      if (hs) begin
        retired <= retired + 32'd1;
        if (!bad_target) pc <= NextPCSrc ? target : pc + 32'd4;
      end
    end
  end

  assign imem_addr    = pc;
  assign PC           = pc;
  assign PCPlus4      = pc + 32'd4;
  assign Inst         = inst;
  assign OpCode       = inst[6:0];
  assign Rd           = inst[11:7];
  assign Funct3       = inst[14:12];
  assign Rs1          = inst[19:15];
  assign Rs2          = inst[24:20];
  assign Funct7       = inst[31:25];
  assign RetiredCount = retired;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Inst;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [31:0] PC, PCPlus4;
  logic        NextPCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] RetiredCount;
  logic        MisalignErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  instruction_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .Inst(Inst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .PC(PC), .PCPlus4(PCPlus4),
    .NextPCSrc(NextPCSrc), .BranchTarget(BranchTarget),
    .RetiredCount(RetiredCount), .MisalignErr(MisalignErr)
  );

  always #5 clk = ~clk;

  // Zero-wait memory model; imem_valid gates when the word is taken.
  assign imem_rdata = mem[imem_addr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0000_0033;   // add  x0,x0,x0
    mem[1]  = 32'h0000_2013;   // slti x0,x0,0
    mem[2]  = 32'h0000_2003;   // lw   x0,0(x0)
    mem[3]  = 32'h0010_8093;   // addi x1,x1,1
    mem[64] = 32'h4020_81B3;   // sub  x3,x1,x2

    rst = 1'b1; imem_valid = 1'b0; inst_ready = 1'b0;
    NextPCSrc = 1'b0; BranchTarget = 32'h0;
    #1;
    chk("rst_req",   {31'd0, imem_req},   32'd1);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc",    PC,                  32'h0);
    chk("rst_ret",   RetiredCount,        32'd0);
    chk("rst_op",    {25'd0, OpCode},     32'h13);
    chk("rst_merr",  {31'd0, MisalignErr}, 32'd0);
    tick();
    rst = 1'b0;

    // Sequential fetch, zero-wait, inst_ready held high
    imem_valid = 1'b1; inst_ready = 1'b1;
    chk("seq_addr0", imem_addr, 32'h0);
    tick();
    chk("seq_v0",  {31'd0, inst_valid}, 32'd1);
    chk("seq_req0", {31'd0, imem_req},  32'd0);
    chk("seq_op0", {25'd0, OpCode}, 32'h33);
    chk("seq_f30", {29'd0, Funct3}, 32'd0);
    tick();
    chk("seq_addr1", imem_addr, 32'h4);
    chk("seq_ret1", RetiredCount, 32'd1);
    tick();
    chk("seq_op1", {25'd0, OpCode}, 32'h13);
    chk("seq_f31", {29'd0, Funct3}, 32'd2);
    tick();
    chk("seq_addr2", imem_addr, 32'h8);
    tick();
    chk("seq_op2", {25'd0, OpCode}, 32'h03);
    chk("seq_f32", {29'd0, Funct3}, 32'd2);
    chk("seq_pc2", PC, 32'h8);

    // Backpressure in ISSUE for 5 cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_inst",  Inst,                 32'h0000_2003);
    chk("bp_pc",    PC,                   32'h8);
    chk("bp_op",    {25'd0, OpCode},      32'h03);
    chk("bp_req",   {31'd0, imem_req},    32'd0);
    chk("bp_valid", {31'd0, inst_valid},  32'd1);
    chk("bp_ret",   RetiredCount,         32'd2);

    // Redirect at PC=0x8 to 0x100; memory then waits 3 cycles
    inst_ready = 1'b1; NextPCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    imem_valid = 1'b0; NextPCSrc = 1'b0;
    chk("rd_addr",  imem_addr,    32'h100);
    chk("rd_pc4",   PCPlus4,      32'h104);
    chk("rd_ret",   RetiredCount, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_addr",  imem_addr,           32'h100);
      chk("ws_valid", {31'd0, inst_valid}, 32'd0);
    end
    chk("ws_ret", RetiredCount, 32'd3);   // inst_ready in FETCH does nothing
    imem_valid = 1'b1;
    tick();
    chk("ws_rise", {31'd0, inst_valid}, 32'd1);
    chk("ws_inst", Inst,            32'h4020_81B3);
    chk("ws_rd",   {27'd0, Rd},     32'd3);
    chk("ws_rs1",  {27'd0, Rs1},    32'd1);
    chk("ws_rs2",  {27'd0, Rs2},    32'd2);
    chk("ws_f7",   {25'd0, Funct7}, 32'h20);

    // Back to 0x8, then sequential to 0xC
    NextPCSrc = 1'b1; BranchTarget = 32'h8;
    tick();
    NextPCSrc = 1'b0;
    chk("back_addr", imem_addr, 32'h8);
    tick();
    tick();
    chk("seqc_addr", imem_addr,    32'hC);
    chk("seqc_ret",  RetiredCount, 32'd5);
    tick();
    chk("seqc_inst", Inst, 32'h0010_8093);

    // Misaligned redirect target
    NextPCSrc = 1'b1; BranchTarget = 32'h102;
    tick();
    NextPCSrc = 1'b0;
    chk("mis_ret", RetiredCount, 32'd6);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_err", {31'd0, MisalignErr}, 32'd1);
    chk("mis_pc",  PC,                   32'hC);
    chk("mis_req", {31'd0, imem_req},    32'd0);
    tick(); tick();
    chk("mis_halt", {31'd0, imem_req},   32'd0);
    chk("mis_hv",   {31'd0, inst_valid}, 32'd0);
`else
    chk("mis_err",  {31'd0, MisalignErr}, 32'd0);
    chk("mis_addr", imem_addr,            32'h100);
    chk("mis_req",  {31'd0, imem_req},    32'd1);
`endif

    // Reset, redirect to top of address space, wrap PC+4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_addr", imem_addr,             32'h0);
    chk("rst2_merr", {31'd0, MisalignErr},  32'd0);
    tick();
    NextPCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick();
    NextPCSrc = 1'b0;
    chk("wrap_pc4", PCPlus4, 32'h0);
    tick();
    NextPCSrc = 1'b1; BranchTarget = 32'h40;
    tick();
    NextPCSrc = 1'b0;
    chk("r40_addr", imem_addr, 32'h40);
    tick();
    chk("r40_valid", {31'd0, inst_valid}, 32'd1);
    chk("r40_pc",    PC, 32'h40);

    // Asynchronous reset mid-ISSUE
    inst_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc",    PC,                  32'h0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_req",   {31'd0, imem_req},   32'd1);
    chk("arst_ret",   RetiredCount,        32'd0);
    chk("arst_op",    {25'd0, OpCode},     32'h13);
    tick();   // imem_valid=1 during rst is ignored
    chk("arst_ign",   {31'd0, inst_valid}, 32'd0);
    chk("arst_inst",  Inst,                32'h13);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
